// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared SECDED sizing helpers and status encoding
package ecc_pkg;

    typedef enum logic [1:0] {
        NoErr     = 2'd0,
        SingleErr = 2'd1,
        DoubleErr = 2'd2
    } ecc_status_e;

    // Number of Hamming parity bits p with 2^p >= data_width + p + 1.
    function automatic int get_cw_width(input int data_width);
        int p;
        p = 1;
        while ((1 << p) < (data_width + p + 1)) begin
            p++;
        end
        return p;
    endfunction

    function automatic int ecc_lane_idx_width(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/ecc_decode.sv
// rtl/ecc_decode.sv - combinational extended-Hamming (SECDED) decoder for one lane
module ecc_decode
    import ecc_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic [DataWidth+get_cw_width(DataWidth):0] codeword,
    output logic [DataWidth-1:0]                       data,
    output logic [get_cw_width(DataWidth)-1:0]         syndrome,
    output logic                                       single_err,
    output logic                                       double_err
);

    localparam int ParityWidth   = get_cw_width(DataWidth);
    localparam int CodeWordWidth = DataWidth + ParityWidth;

    function automatic logic [CodeWordWidth-1:0] syn_mask(input int bit_idx);
        logic [CodeWordWidth-1:0] m;
        m = '0;
        for (int j = 0; j < CodeWordWidth; j++) begin
            m[j] = (((j + 1) >> bit_idx) & 1) != 0;
        end
        return m;
    endfunction

    // Code index of the data_idx-th non-power-of-two position.
    function automatic int data_pos(input int data_idx);
        int k;
        int pos;
        k   = 0;
        pos = 0;
        for (int j = 0; j < CodeWordWidth; j++) begin
            if (((j + 1) & j) != 0) begin
                if (k == data_idx) pos = j;
                k++;
            end
        end
        return pos;
    endfunction

    for (genvar i = 0; i < ParityWidth; i++) begin : g_syn
        localparam logic [CodeWordWidth-1:0] Mask = syn_mask(i);
        assign syndrome[i] = ^(codeword[CodeWordWidth-1:0] & Mask);
    end

    // Syndromes pointing past the codeword match no position, so data passes through.
    for (genvar d = 0; d < DataWidth; d++) begin : g_data
        localparam int Pos = data_pos(d);
        assign data[d] = codeword[Pos] ^ (syndrome == ParityWidth'(Pos + 1));
    end

    logic        parity;
    ecc_status_e status;

    assign parity = ^codeword;

    always_comb begin
        status = NoErr;
        if (parity) begin
            status = SingleErr;
        end else if (syndrome != '0) begin
            status = DoubleErr;
        end
    end

    assign single_err = (status == SingleErr);
    assign double_err = (status == DoubleErr);

endmodule

// File: rtl/ecc_decode_stream.sv
// rtl/ecc_decode_stream.sv - multi-lane streaming SECDED decoder with error counters and capture
module ecc_decode_stream
    import ecc_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int NumLanes      = 4,
    parameter int CntWidth      = 16,
    parameter int ParityWidth   = get_cw_width(DataWidth),
    parameter int CodeWordWidth = DataWidth + ParityWidth,
    parameter int LaneIdxWidth  = ecc_lane_idx_width(NumLanes)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [NumLanes*(CodeWordWidth+1)-1:0] in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [NumLanes*DataWidth-1:0]        out_data_o,
    output logic [NumLanes-1:0]                  out_single_err_o,
    output logic [NumLanes-1:0]                  out_double_err_o,
    output logic [NumLanes*ParityWidth-1:0]      out_syndrome_o,
    input  logic                                 clear_i,
    output logic [CntWidth-1:0]                  single_cnt_o,
    output logic [CntWidth-1:0]                  double_cnt_o,
    output logic                                 first_dbl_valid_o,
    output logic [LaneIdxWidth-1:0]              first_dbl_lane_o,
    output logic [ParityWidth-1:0]               first_dbl_syndrome_o
);

    localparam int LaneWidth = CodeWordWidth + 1;
    localparam int IncWidth  = LaneIdxWidth + 1;
    localparam int SumWidth  = CntWidth + LaneIdxWidth + 1;
    localparam logic [SumWidth-1:0] CntMax = (SumWidth'(1) << CntWidth) - SumWidth'(1);

    logic [NumLanes*DataWidth-1:0]   dec_data;
    logic [NumLanes-1:0]             dec_single;
    logic [NumLanes-1:0]             dec_double;
    logic [NumLanes*ParityWidth-1:0] dec_syndrome;

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        ecc_decode #(
            .DataWidth(DataWidth)
        ) u_dec (
            .codeword  (in_data_i[k*LaneWidth +: LaneWidth]),
            .data      (dec_data[k*DataWidth +: DataWidth]),
            .syndrome  (dec_syndrome[k*ParityWidth +: ParityWidth]),
            .single_err(dec_single[k]),
            .double_err(dec_double[k])
        );
    end

    logic                    accept;
    logic [IncWidth-1:0]     single_inc;
    logic [IncWidth-1:0]     double_inc;
    logic [LaneIdxWidth-1:0] dbl_lane;
    logic [ParityWidth-1:0]  dbl_syndrome;

    assign in_ready_o = ~out_valid_o | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;
    assign single_inc = accept ? IncWidth'($countones(dec_single)) : '0;
    assign double_inc = accept ? IncWidth'($countones(dec_double)) : '0;

    // Walk downward so the lowest failing lane wins.
    always_comb begin
        dbl_lane     = '0;
        dbl_syndrome = '0;
        for (int k = NumLanes - 1; k >= 0; k--) begin
            if (dec_double[k]) begin
                dbl_lane     = LaneIdxWidth'(k);
                dbl_syndrome = dec_syndrome[k*ParityWidth +: ParityWidth];
            end
        end
    end

    function automatic logic [CntWidth-1:0] next_count(input logic [CntWidth-1:0] cur,
                                                       input logic                clr,
                                                       input logic [IncWidth-1:0] inc);
        logic [SumWidth-1:0] sum;
        sum = (clr ? '0 : SumWidth'(cur)) + SumWidth'(inc);
        return (sum > CntMax) ? CntMax[CntWidth-1:0] : sum[CntWidth-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o      <= 1'b0;
            out_data_o       <= '0;
            out_single_err_o <= '0;
            out_double_err_o <= '0;
            out_syndrome_o   <= '0;
        end else if (in_ready_o) begin
            out_valid_o <= in_valid_i;
            if (in_valid_i) begin
                out_data_o       <= dec_data;
                out_single_err_o <= dec_single;
                out_double_err_o <= dec_double;
                out_syndrome_o   <= dec_syndrome;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            single_cnt_o <= '0;
            double_cnt_o <= '0;
        end else if (accept | clear_i) begin
            single_cnt_o <= next_count(single_cnt_o, clear_i, single_inc);
            double_cnt_o <= next_count(double_cnt_o, clear_i, double_inc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_dbl_valid_o    <= 1'b0;
            first_dbl_lane_o     <= '0;
            first_dbl_syndrome_o <= '0;
        end else if (accept & (|dec_double) & (~first_dbl_valid_o | clear_i)) begin
            first_dbl_valid_o    <= 1'b1;
            first_dbl_lane_o     <= dbl_lane;
            first_dbl_syndrome_o <= dbl_syndrome;
        end else if (clear_i) begin
            first_dbl_valid_o    <= 1'b0;
            first_dbl_lane_o     <= '0;
            first_dbl_syndrome_o <= '0;
        end
    end

endmodule

// File: doc/ecc_decode_stream.md
# ecc_decode_stream

Streaming, multi-lane SECDED decoder. It accepts a beat of `NumLanes` extended-Hamming codewords on a valid/ready handshake and decodes every lane in parallel. It returns corrected data and per-lane status one cycle later through a registered output stage. It also keeps saturating single- and double-error counters and a sticky capture of the first uncorrectable error. It sits between ECC-protected memories or links and their consumers, and feeds error telemetry to a status/CSR block.

## Interface
- `DataWidth`, 64: data bits per lane.
- `NumLanes`, 4: codewords per beat, ≥1.
- `CntWidth`, 16: width of each error counter.
- `ParityWidth`, `ecc_pkg::get_cw_width(DataWidth)`: Hamming parity bits per lane; derived, do not override.
- `CodeWordWidth`, `DataWidth+ParityWidth`: derived, do not override.
- `LaneIdxWidth`, `NumLanes>1 ? $clog2(NumLanes) : 1`: derived.

Ports (`clk_i` and `rst_i` first):
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  input beat accepted when high together with valid.
- `in_data_i`  in  NumLanes×(CodeWordWidth+1)  lane k occupies bits [k·(CodeWordWidth+1) +: CodeWordWidth+1]; MSB of each lane is the overall parity bit.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  downstream accepts.
- `out_data_o`  out  NumLanes×DataWidth  corrected data, packed lane order.
- `out_single_err_o`  out  NumLanes  per-lane correctable error, including an overall-parity-bit-only error.
- `out_double_err_o`  out  NumLanes  per-lane uncorrectable error.
- `out_syndrome_o`  out  NumLanes×ParityWidth  per-lane syndrome.
- `clear_i`  in  1  synchronous clear of counters and capture.
- `single_cnt_o`  out  CntWidth  saturating count of corrected lanes.
- `double_cnt_o`  out  CntWidth  saturating count of uncorrectable lanes.
- `first_dbl_valid_o`  out  1  sticky: a double error has been captured.
- `first_dbl_lane_o`  out  LaneIdxWidth  lane of the first double error.
- `first_dbl_syndrome_o`  out  ParityWidth  syndrome of the first double error.

## Operation
- Each lane is decoded combinationally.
  - Syndrome bit i is the XOR of code bits j where (j+1)&2^i≠0.
  - Overall parity is the MSB XOR the XOR of the lower bits.
  - A nonzero syndrome flips code bit (syndrome−1). If syndrome−1 ≥ CodeWordWidth, the data passes uncorrected and only the flags are reported.
  - Data bits are the non-power-of-two positions, in ascending order.
- Error classification:
  - single = parity.
  - double = ~parity & (syndrome≠0).
  - none otherwise.
- Accept: `in_valid_i & in_ready_o`. The decoded beat and status are loaded into the output register.
- `in_ready_o = ~out_valid_o | out_ready_i`, so there are no bubbles at full throughput.
- Output registers hold stable while `out_valid_o & ~out_ready_i`.
- Counters update on accept.
  - Increment = popcount of the lane flags, range 0..NumLanes.
  - The sum is computed CntWidth+LaneIdxWidth+1 bits wide and clamped to 2^CntWidth−1.
- `clear_i` has precedence over the old value. With clear and accept in the same cycle, counter = clamp(increment) and the capture takes the current beat.
- Capture: when `first_dbl_valid_o` is 0 and an accepted beat has any double error, store the lowest-index failing lane and its syndrome, and set valid.
  - Later double errors are ignored until `clear_i`.
  - `clear_i` without a same-cycle double error resets valid, lane and syndrome to 0.

## Timing
- Latency: accept at cycle N, so `out_valid_o` is high in N+1 with that beat's data and status. Counters and capture also reflect the beat in N+1.
- Throughput: one beat per cycle while `out_ready_i` is high.
- Reset values:
  - `out_valid_o`=0.
  - All out_data, flags and syndromes = 0.
  - Counters = 0; `first_dbl_*` = 0.
  - `in_ready_o`=1 in the cycle after reset.
- Reset asserted mid-transfer drops the held beat; no output handshake occurs for it.
- `in_ready_o` is combinational from `out_ready_i`. No combinational path runs from `in_valid_i` to `in_ready_o`.
- Saturated counters stay at max until `clear_i`.

## Structure
- `ecc_pkg`: keep `get_cw_width`.
  - Add the `ecc_status_e` enum (NoErr, SingleErr, DoubleErr).
  - Add the function `ecc_lane_idx_width(NumLanes)`.
- Instantiate the existing combinational `ecc_decode` once per lane, with DataWidth as here, in a generate loop.
- This block adds only the handshake register, counters and capture logic.

## Test plan
All cases use DataWidth=8 (ParityWidth=4, lane width 13), NumLanes=2, CntWidth=3.
- All-zero codewords on both lanes → data 0x00, no flags, syndromes 0, counters stay 0.
- Lane0 bit 2 flipped (0x0004) → lane0 data 0x00, single=1, syndrome 3; single_cnt=1 in the next cycle.
- Lane1 bits 0 and 1 flipped (0x0003) → lane1 double=1, syndrome 3; capture lane=1, syndrome=3. A following double error on lane0 leaves the capture unchanged.
- Lane0 bit 12 only (0x1000) → single=1, syndrome 0, data 0x00.
- 10 consecutive single-error beats with both lanes erroneous → single_cnt saturates at 7. Then `clear_i` with an accepted single-error beat → single_cnt=2.
- Hold `out_ready_i`=0 for 3 cycles with valid input → outputs stable, `in_ready_o`=0. Release → both beats are delivered in order with no loss. Assert `rst_i` mid-stall → `out_valid_o`=0 in the next cycle.
